prom_prog_ctrl: RTL and testbench
=================================

Name: prom_prog_ctrl

Overview:
Sequencer that owns the control pins of the 16x8 program memory (prom16_8bit). In RUN mode it passes the CPU's address and active-low output enable straight through. In PROGRAM mode it accepts a stream of bytes over a valid/ready handshake and writes them to addresses 0..15 in order. It pulses the memory's active-low load strobe once per byte. It also blocks CPU reads so the bus has exactly one owner at any time.

Parameters:
DATA_W, 8, memory word width
ADDR_W, 4, memory address width
DEPTH, 16, words per programming session (must equal 2**ADDR_W)

Ports:
clk  input  1  system clock, rising-edge
clr  input  1  synchronous active-high reset
prog_start  input  1  single-cycle request to begin a programming session
prog_abort  input  1  ends the session early without a done pulse
in_data  input  DATA_W  byte to be written
in_valid  input  1  in_data is valid
in_ready  output  1  controller accepts in_data this cycle
cpu_addr  input  ADDR_W  CPU address (from MAR)
cpu_rd_n  input  1  CPU active-low read enable
mem_addr  output  ADDR_W  to memory addr
mem_data  output  DATA_W  to memory data_in
mem_low_load  output  1  to memory low_load (active low)
mem_low_o_en  output  1  to memory low_o_en (active low)
busy  output  1  a programming session is in progress
done  output  1  one-cycle pulse after the last word is written
wr_count  output  ADDR_W+1  words written in the current or most recent session (0..16)

Behaviour:
- States are RUN, LOAD, WRITE and DONE. The state register, write pointer ptr, data latch and wr_count are all clocked on clk.
- Reset (clr=1 at a rising edge) forces state=RUN, ptr=0, wr_count=0 and data latch=0. It takes priority over every other input and applies in any state, including mid-WRITE.
- Memory contents are not touched by clr.
- After reset: busy=0, done=0, in_ready=0, mem_low_load=1, mem_data=0.
- RUN:
  - mem_addr=cpu_addr and mem_low_o_en=cpu_rd_n, combinational with zero latency.
  - mem_low_load=1, in_ready=0, busy=0.
  - prog_start=1 → go to LOAD; ptr←0, wr_count←0.
- LOAD:
  - busy=1, mem_low_o_en=1 (CPU read is ignored), mem_low_load=1, mem_addr=ptr.
  - in_ready = ~prog_abort.
  - prog_abort=1 → go to RUN. wr_count is held. The byte is not accepted, even if in_valid=1 in the same cycle.
  - Otherwise, in_valid & in_ready → latch in_data and go to WRITE.
  - in_valid=0 → stay in LOAD indefinitely.
- WRITE:
  - Exactly one cycle. busy=1, in_ready=0, mem_low_o_en=1, mem_addr=ptr, mem_data=latch, mem_low_load=0.
  - The memory captures the word on the rising edge that ends this cycle.
  - On that edge wr_count is incremented.
  - If ptr = DEPTH-1, go to DONE with ptr wrapping to 0. Otherwise ptr increments and the next state is LOAD.
  - prog_abort is ignored in WRITE, so a started write always completes.
- DONE:
  - One cycle: done=1, busy=1, mem_low_load=1, mem_low_o_en=1, in_ready=0.
  - Then go to RUN. wr_count=16 is held until the next prog_start or clr.
- prog_start is ignored whenever state≠RUN.
- Throughput is 2 cycles per byte with in_valid held high. A full session takes 33 cycles from the prog_start edge to the done pulse.
- mem_low_load and mem_low_o_en are never both 0 in the same cycle.
- mem_low_load is low only in WRITE.
- mem_data only changes on a handshake or on clr.

Test Plan:
1. Reset check: clr=1 for 2 cycles. Then expect busy=0, in_ready=0, mem_low_load=1, wr_count=0. Drive cpu_addr=5, cpu_rd_n=0 → mem_addr=5 and mem_low_o_en=0 in the same cycle.
2. Full session: pulse prog_start, hold in_valid=1, send in_data=0x10+i for i=0..15. Expect:
   - 16 single-cycle mem_low_load=0 strobes at mem_addr=i.
   - done high exactly 33 cycles after prog_start is sampled, wr_count=16.
   - A RUN-mode readback through a prom16_8bit model returns 0x10+i at address i.
3. Backpressure: same session with in_valid toggled in a pseudo-random pattern → no strobe while waiting, stored data is still 0x10+i in order, done arrives later than cycle 33.
4. Abort: prog_abort=1 in LOAD after 5 bytes (in_valid=1 in the same cycle) → RUN next cycle, wr_count=5, no done pulse. Addresses 5..15 keep their prior values (0x11 prefill).
5. Bus isolation: hold cpu_rd_n=0 and cpu_addr=0xF throughout a session → mem_low_o_en=1 and mem_addr=ptr while busy. A second prog_start mid-session has no effect.
6. Reset mid-write: assert clr during the WRITE for ptr=7 → RUN on the next cycle, mem_low_load=1, wr_count=0, busy=0. The next prog_start restarts the session at address 0.

Source files
------------

// File: rtl/prom_prog_ctrl.sv
// Owns the control pins of the 16x8 program memory: CPU pass-through in RUN, byte-stream programming otherwise.
// Zero-latency pass-through in RUN; 2 cycles per byte while programming; in_ready stalls the stream during each write.
module prom_prog_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              prog_start,
  input  logic              prog_abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_low_load,
  output logic              mem_low_o_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nxt;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W:0]   wr_count_q;
  logic [ADDR_W:0]   wr_count_nxt;
  logic              load_en;

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= ST_RUN;
      ptr        <= '0;
      wr_count_q <= '0;
      data_q     <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      wr_count_q <= wr_count_nxt;
      if (load_en) begin
        data_q <= in_data;
      end
    end
  end

  // Outside RUN the controller is the only bus owner: CPU reads are masked.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    wr_count_nxt = wr_count_q;
    load_en      = 1'b0;
    in_ready     = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    mem_low_load = 1'b1;
    mem_low_o_en = 1'b1;
    mem_addr     = ptr;
    case (state)
      ST_RUN: begin
        busy         = 1'b0;
        mem_addr     = cpu_addr;
        mem_low_o_en = cpu_rd_n;
        if (prog_start) begin
          state_nxt    = ST_LOAD;
          ptr_nxt      = '0;
          wr_count_nxt = '0;
        end
      end
      ST_LOAD: begin
        in_ready = ~prog_abort;
        if (prog_abort) begin
          state_nxt = ST_RUN;
        end else if (in_valid) begin
          load_en   = 1'b1;
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Abort is deliberately not looked at here so a started write finishes.
        mem_low_load = 1'b0;
        wr_count_nxt = wr_count_q + (ADDR_W + 1)'(1);
        if (ptr == LAST_ADDR) begin
          ptr_nxt   = '0;
          state_nxt = ST_DONE;
        end else begin
          ptr_nxt   = ptr + ADDR_W'(1);
          state_nxt = ST_LOAD;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  assign mem_data = data_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_prom_prog_ctrl.sv
// Bench for prom_prog_ctrl: a prom16_8bit model on the memory pins plus a transaction-level session model.
module tb_prom_prog_ctrl;

  logic       clk;
  logic       clr;
  logic       prog_start;
  logic       prog_abort;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] cpu_addr;
  logic       cpu_rd_n;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_low_load;
  logic       mem_low_o_en;
  logic       busy;
  logic       done;
  logic [4:0] wr_count;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 0;

  logic [7:0] tbmem   [16];
  logic [7:0] exp_mem [16];

  prom_prog_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut (
    .clk(clk), .clr(clr), .prog_start(prog_start), .prog_abort(prog_abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cpu_addr(cpu_addr), .cpu_rd_n(cpu_rd_n),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_low_load(mem_low_load),
    .mem_low_o_en(mem_low_o_en), .busy(busy), .done(done), .wr_count(wr_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // prom16_8bit behaviour: word captured on the rising edge while low_load is low.
  always @(posedge clk) begin
    if (mem_low_load === 1'b0) tbmem[mem_addr] <= mem_data;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      n_chk++;
      if (mem_low_load !== 1'b1 && mem_low_o_en !== 1'b1) begin
        n_fail++;
        $display("FAIL bus_owner: low_load=%b low_o_en=%b, required not both 0", mem_low_load, mem_low_o_en);
      end
    end
  end

  task automatic sync;
    @(posedge clk);
    #1;
  endtask

  task automatic readback(input string tag);
    for (int a = 0; a < 16; a++) begin
      cpu_addr = 4'(a);
      cpu_rd_n = 1'b0;
      #1;
      n_chk++;
      if (mem_addr !== 4'(a) || mem_low_o_en !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_run_pass: addr=%h oen=%b busy=%b, required addr=%h oen=0 busy=0",
                 tag, mem_addr, mem_low_o_en, busy, 4'(a));
      end
      n_chk++;
      if (tbmem[mem_addr] !== exp_mem[a]) begin
        n_fail++;
        $display("FAIL %s_readback[%0d]: got %h, required %h", tag, a, tbmem[mem_addr], exp_mem[a]);
      end
    end
    cpu_rd_n = 1'b1;
    cpu_addr = 4'h0;
  endtask

  // One programming session driven and checked against a count-based model.
  // cdat: every byte is base; otherwise byte i is base+i.
  task automatic run_session(input string tag, input logic [7:0] base, input bit cdat, input bit bp,
                             input int abort_at, input int clr_at, input bit iso, output int done_cyc);
    int idx = 0;
    int wcnt = 0;
    bit hs = 0;
    bit wr = 0;
    bit ed = 0;
    bit was_done = 0;
    bit fin = 0;
    bit rdy;
    logic [7:0] dat;
    logic [3:0] eaddr;
    done_cyc = -1;
    sync();
    cpu_rd_n   = iso ? 1'b0 : 1'b1;
    cpu_addr   = iso ? 4'hF : 4'h0;
    prog_start = 1'b1;
    in_valid   = 1'b0;
    sync();
    prog_start = 1'b0;
    for (int cyc = 1; cyc < 400 && !fin; cyc++) begin
      if (wr) wcnt++;
      ed = wr && (wcnt == 16);
      wr = hs;
      if (hs) idx++;
      if (was_done) begin
        #1;
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || wr_count !== 5'd16) begin
          n_fail++;
          $display("FAIL %s_after_done: busy=%b done=%b rdy=%b cnt=%0d, required 0 0 0 16",
                   tag, busy, done, in_ready, wr_count);
        end
        fin = 1;
      end else begin
        dat        = cdat ? base : base + idx[7:0];
        in_valid   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data    = dat;
        prog_abort = (abort_at == idx) && !wr && !ed;
        prog_start = iso && (cyc == 10);
        clr        = (clr_at >= 0) && wr && (idx - 1 == clr_at);
        #1;
        rdy   = !wr && !ed && !prog_abort;
        eaddr = 4'(wr ? idx - 1 : idx);
        n_chk++;
        if (busy !== 1'b1 || done !== ed || in_ready !== rdy || mem_low_load !== !wr || mem_low_o_en !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_ctrl cyc%0d: busy=%b done=%b rdy=%b load=%b oen=%b, required 1 %b %b %b 1",
                   tag, cyc, busy, done, in_ready, mem_low_load, mem_low_o_en, ed, rdy, !wr);
        end
        n_chk++;
        if (mem_addr !== eaddr || wr_count !== 5'(wcnt)) begin
          n_fail++;
          $display("FAIL %s_addr_cnt cyc%0d: addr=%h cnt=%0d, required addr=%h cnt=%0d",
                   tag, cyc, mem_addr, wr_count, eaddr, wcnt);
        end
        if (wr) begin
          n_chk++;
          if (mem_data !== (cdat ? base : base + 8'(idx - 1))) begin
            n_fail++;
            $display("FAIL %s_wdata cyc%0d: got %h, required %h", tag, cyc, mem_data,
                     cdat ? base : base + 8'(idx - 1));
          end
        end
        if (ed) begin
          done_cyc = cyc;
          was_done = 1;
        end
        hs = in_valid && rdy;
        if (hs) exp_mem[idx] = dat;
        if (prog_abort || clr) begin
          sync();
          prog_abort = 1'b0;
          clr        = 1'b0;
          in_valid   = 1'b0;
          #1;
          n_chk++;
          if (busy !== 1'b0 || in_ready !== 1'b0 || mem_low_load !== 1'b1 ||
              wr_count !== (clr_at >= 0 ? 5'd0 : 5'(idx))) begin
            n_fail++;
            $display("FAIL %s_early_end: busy=%b rdy=%b load=%b cnt=%0d, required 0 0 1 %0d",
                     tag, busy, in_ready, mem_low_load, wr_count, clr_at >= 0 ? 0 : idx);
          end
          for (int k = 0; k < 4; k++) begin
            sync();
            n_chk++;
            if (done !== 1'b0 || busy !== 1'b0) begin
              n_fail++;
              $display("FAIL %s_no_done: done=%b busy=%b, required 0 0", tag, done, busy);
            end
          end
          fin = 1;
        end
      end
      if (!fin) sync();
    end
    in_valid   = 1'b0;
    prog_start = 1'b0;
    cpu_rd_n   = 1'b1;
    cpu_addr   = 4'h0;
    if (!fin) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: session did not end within cycle budget", tag);
    end
  endtask

  task automatic test_reset;
    clr = 1'b1;
    sync();
    sync();
    clr = 1'b0;
    #1;
    mon_en = 1;
    n_chk++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || mem_low_load !== 1'b1 || done !== 1'b0 ||
        wr_count !== 5'd0 || mem_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b rdy=%b load=%b done=%b cnt=%0d data=%h, required 0 0 1 0 0 00",
               busy, in_ready, mem_low_load, done, wr_count, mem_data);
    end
    cpu_addr = 4'h5;
    cpu_rd_n = 1'b0;
    #1;
    n_chk++;
    if (mem_addr !== 4'h5 || mem_low_o_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_passthru: addr=%h oen=%b, required 5 0", mem_addr, mem_low_o_en);
    end
    cpu_rd_n = 1'b1;
  endtask

  task automatic test_full_session;
    int dc;
    run_session("full", 8'h10, 0, 0, -1, -1, 0, dc);
    n_chk++;
    if (dc != 33) begin
      n_fail++;
      $display("FAIL full_done_cycle: got %0d, required 33", dc);
    end
    readback("full");
  endtask

  task automatic test_backpressure;
    int dc;
    run_session("prefill", 8'h11, 1, 0, -1, -1, 0, dc);
    run_session("bp", 8'h10, 0, 1, -1, -1, 0, dc);
    n_chk++;
    if (dc <= 33) begin
      n_fail++;
      $display("FAIL bp_done_cycle: got %0d, required > 33", dc);
    end
    readback("bp");
  endtask

  task automatic test_abort;
    int dc;
    run_session("prefill", 8'h11, 1, 0, -1, -1, 0, dc);
    run_session("abort", 8'h10, 0, 0, 5, -1, 0, dc);
    n_chk++;
    if (dc != -1) begin
      n_fail++;
      $display("FAIL abort_done: done seen at cycle %0d, required none", dc);
    end
    readback("abort");
  endtask

  task automatic test_bus_isolation;
    int dc;
    run_session("iso", 8'($urandom), 0, 1, -1, -1, 1, dc);
    n_chk++;
    if (dc < 33) begin
      n_fail++;
      $display("FAIL iso_done_cycle: got %0d, required >= 33", dc);
    end
    readback("iso");
  endtask

  task automatic test_clr_mid_write;
    int dc;
    run_session("clrmid", 8'h80, 0, 0, -1, 7, 0, dc);
    run_session("restart", 8'($urandom), 0, 0, -1, -1, 0, dc);
    n_chk++;
    if (dc != 33) begin
      n_fail++;
      $display("FAIL restart_done_cycle: got %0d, required 33", dc);
    end
    readback("restart");
  endtask

  initial begin
    clr        = 1'b1;
    prog_start = 1'b0;
    prog_abort = 1'b0;
    in_data    = 8'h00;
    in_valid   = 1'b0;
    cpu_addr   = 4'h0;
    cpu_rd_n   = 1'b1;
    test_reset();
    test_full_session();
    test_backpressure();
    test_abort();
    test_bus_isolation();
    test_clr_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
